// File: rtl/wb_regfile.sv
// Write-back end of the pipeline: GPR file plus HI/LO pair,
// two combinational read ports with same-cycle write bypass.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] hi_d, lo_d;
  logic              gpr_wr;

  assign gpr_wr = we && (waddr != '0);
  assign hi_d   = whilo ? hi_i : hi_q;
  assign lo_d   = whilo ? lo_i : lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (gpr_wr)
        regs_q[waddr] <= wdata;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // r0 wins over bypass so a dropped write to r0 never leaks out
  always_comb begin
    rdata1 = '0;
    if (rst || raddr1 == '0 || !re1)
      rdata1 = '0;
    else if (we && waddr == raddr1)
      rdata1 = wdata;
    else
      rdata1 = regs_q[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (rst || raddr2 == '0 || !re2)
      rdata2 = '0;
    else if (we && waddr == raddr2)
      rdata2 = wdata;
    else
      rdata2 = regs_q[raddr2];
  end

  assign hi_o = rst ? '0 : hi_d;
  assign lo_o = rst ? '0 : lo_d;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases
// followed by random traffic against an array model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        whilo;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  logic [31:0] mreg [32];
  logic [31:0] mhi;
  logic [31:0] mlo;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re1   (re1),
    .raddr1(raddr1),
    .rdata1(rdata1),
    .re2   (re2),
    .raddr2(raddr2),
    .rdata2(rdata2),
    .whilo (whilo),
    .hi_i  (hi_i),
    .lo_i  (lo_i),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_rd(input logic en,
                                         input logic [4:0] a);
    if (rst)
      return 32'h0;
    if (a == 5'd0)
      return 32'h0;
    if (en && we && waddr == a)
      return wdata;
    if (en)
      return mreg[a];
    return 32'h0;
  endfunction

  // check all outputs against the model, then commit the edge
  task automatic cycle();
    #1;
    chk("rd1", rdata1, exp_rd(re1, raddr1));
    chk("rd2", rdata2, exp_rd(re2, raddr2));
    chk("hi", hi_o, rst ? 32'h0 : (whilo ? hi_i : mhi));
    chk("lo", lo_o, rst ? 32'h0 : (whilo ? lo_i : mlo));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++)
        mreg[i] = 32'h0;
      mhi = 32'h0;
      mlo = 32'h0;
    end else begin
      if (we && waddr != 5'd0)
        mreg[waddr] = wdata;
      if (whilo) begin
        mhi = hi_i;
        mlo = lo_i;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; we = 0; waddr = 0; wdata = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    whilo = 0; hi_i = 0; lo_i = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      mreg[i] = 32'h0;
    mhi = 32'h0;
    mlo = 32'h0;
    idle();
    @(negedge clk);

    // reset with a write pending
    rst = 1; we = 1; waddr = 5; wdata = 32'hDEADBEEF;
    re1 = 1; raddr1 = 5; whilo = 1; hi_i = 32'h5; lo_i = 32'h6;
    #1 chk("rst_rd1", rdata1, 32'h0);
    chk("rst_hi", hi_o, 32'h0);
    cycle();
    cycle();
    idle();
    re1 = 1; raddr1 = 5;
    #1 chk("post_rst_r5", rdata1, 32'h0);
    chk("post_rst_hi", hi_o, 32'h0);
    chk("post_rst_lo", lo_o, 32'h0);
    cycle();

    // write then read back on both ports
    idle();
    we = 1; waddr = 7; wdata = 32'h12345678;
    cycle();
    idle();
    re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 7;
    #1 chk("r7_p1", rdata1, 32'h12345678);
    chk("r7_p2", rdata2, 32'h12345678);
    cycle();
    re2 = 0;
    #1 chk("r7_p2_off", rdata2, 32'h0);
    cycle();

    // same-cycle bypass
    idle();
    we = 1; waddr = 9; wdata = 32'hA5A5A5A5; re1 = 1; raddr1 = 9;
    re2 = 1; raddr2 = 9;
    #1 chk("byp_p1", rdata1, 32'hA5A5A5A5);
    chk("byp_p2", rdata2, 32'hA5A5A5A5);
    cycle();
    we = 0;
    #1 chk("byp_held", rdata1, 32'hA5A5A5A5);
    cycle();

    // register zero
    idle();
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF; re1 = 1; raddr1 = 0;
    #1 chk("r0_same", rdata1, 32'h0);
    cycle();
    we = 0;
    #1 chk("r0_later", rdata1, 32'h0);
    cycle();

    // HI/LO
    idle();
    whilo = 1; hi_i = 32'h11; lo_i = 32'h22;
    #1 chk("hilo_byp_hi", hi_o, 32'h11);
    chk("hilo_byp_lo", lo_o, 32'h22);
    cycle();
    whilo = 0; hi_i = 32'h99;
    #1 chk("hilo_held_hi", hi_o, 32'h11);
    chk("hilo_held_lo", lo_o, 32'h22);
    cycle();

    // back-to-back overwrite
    idle();
    re1 = 1; raddr1 = 3;
    for (int v = 1; v <= 3; v++) begin
      we = 1; waddr = 3; wdata = v;
      #1 chk("b2b", rdata1, v);
      cycle();
    end
    we = 0;
    #1 chk("b2b_hold", rdata1, 32'd3);
    cycle();

    // reset mid-sequence drops the same-cycle write
    idle();
    rst = 1; we = 1; waddr = 10; wdata = 32'hCAFEF00D;
    cycle();
    idle();
    re1 = 1; raddr1 = 10; re2 = 1; raddr2 = 7;
    #1 chk("mid_rst_r10", rdata1, 32'h0);
    chk("mid_rst_r7", rdata2, 32'h0);
    cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 39) == 0);
      we    = $urandom_range(0, 1);
      waddr = $urandom_range(0, 31);
      wdata = $urandom;
      re1   = ($urandom_range(0, 3) != 0);
      re2   = ($urandom_range(0, 3) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      whilo = $urandom_range(0, 1);
      hi_i  = $urandom;
      lo_i  = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Write-back end of the CPU pipeline. It consumes the write-back bundle (register write plus HI/LO write) and owns the architectural state: a 32-entry general-purpose register file and the HI/LO register pair. It serves two combinational read ports to the decode stage. Same-cycle write-to-read bypass means decode never sees a stale value for an instruction that is retiring in the same cycle.

Parameters:
DATA_W, 32, register/data width in bits
ADDR_W, 5, register address width
NREG, 32, number of GPRs (must equal 2**ADDR_W)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
we  input  1  GPR write enable from write-back bundle
waddr  input  ADDR_W  GPR write address
wdata  input  DATA_W  GPR write data
re1  input  1  read port 1 enable
raddr1  input  ADDR_W  read port 1 address
rdata1  output  DATA_W  read port 1 data (combinational)
re2  input  1  read port 2 enable
raddr2  input  ADDR_W  read port 2 address
rdata2  output  DATA_W  read port 2 data (combinational)
whilo  input  1  HI/LO write enable
hi_i  input  DATA_W  HI write data
lo_i  input  DATA_W  LO write data
hi_o  output  DATA_W  current HI (combinational, bypassed)
lo_o  output  DATA_W  current LO (combinational, bypassed)

Behaviour:
- Reset: synchronous, active-high. At a rising clk with rst=1, all NREG GPRs, HI and LO are cleared to 0. Writes presented in that cycle are discarded.
- Outputs during reset: while rst=1, rdata1, rdata2, hi_o and lo_o are forced to 0 combinationally, regardless of the other inputs.
- GPR write: at a rising clk with rst=0, we=1 and waddr!=0, reg[waddr] <= wdata. Writes to address 0 are dropped; reg[0] is always 0.
- Read port n (identical logic per port, evaluated in priority order):
  - rst=1 -> 0
  - else raddrn==0 -> 0 (also true when we=1 and waddr=0)
  - else ren=1 && we=1 && waddr==raddrn -> wdata (bypass)
  - else ren=1 -> reg[raddrn]
  - else -> 0
- Read latency: 0 cycles, purely combinational from inputs and state. Write latency: visible through the storage path from the cycle after the write edge, and through bypass in the same cycle.
- Both ports may read the same address, including the address currently being written; both return the bypassed wdata.
- HI/LO write: at a rising clk with rst=0 and whilo=1, HI <= hi_i and LO <= lo_i. HI and LO are always written as a pair.
- HI/LO read:
  - rst=1 -> 0
  - else whilo=1 -> hi_o=hi_i, lo_o=lo_i (bypass)
  - else -> stored HI/LO
- No stall input. The upstream pipeline register already delivers a bubble (we=0, whilo=0) when stalled, so every presented write is committed.
- Reset asserted mid-sequence: the state is cleared at the next edge. Writes issued in that same cycle are lost and must not appear after reset deasserts.
- Width rules: no arithmetic. All data is passed through unmodified at DATA_W bits.

Test Plan:
- Reset then read: rst=1 for 2 cycles with we=1, waddr=5, wdata=0xDEADBEEF; release, read r5 with re1=1 -> rdata1=0, hi_o=lo_o=0.
- Write/read-back: write r7=0x12345678; next cycle read r7 on both ports -> 0x12345678 on rdata1 and rdata2; with re2=0 -> rdata2=0.
- Bypass: we=1, waddr=9, wdata=0xA5A5A5A5 while raddr1=9, re1=1 in the same cycle -> rdata1=0xA5A5A5A5 before the edge; after the edge, with we=0 -> still 0xA5A5A5A5.
- Register zero: we=1, waddr=0, wdata=0xFFFFFFFF with raddr1=0, re1=1 -> rdata1=0 both in the same cycle and on later reads.
- HI/LO: whilo=1, hi_i=0x11, lo_i=0x22 -> hi_o=0x11, lo_o=0x22 in the same cycle; next cycle whilo=0, hi_i=0x99 -> hi_o stays 0x11.
- Back-to-back overwrite: write r3=1, r3=2, r3=3 on consecutive cycles while reading r3 every cycle -> rdata1 sequence 1, 2, 3 (bypass), then 3 held once we=0.
